cmp_share_arb: RTL and testbench

Shares one 32-bit equality comparator between two requesters: port 0 is the ID-stage branch unit (beq/bne), port 1 is the trap/compare unit (teq/tne). A round-robin arbiter accepts one request at a time with a valid/ready handshake. It registers the operands, evaluates equal / not-equal in a dedicated cycle, and holds the tagged result until the consumer accepts it. The block sits between the decode-stage operand muxes and the branch/trap resolution logic.

---
 rtl/cmp_share_pkg.sv | 13 +
 rtl/cmp_share_arb_rr_arb2.sv | 29 ++
 rtl/cmp_share_arb.sv | 99 +++++++++
 tb/tb_cmp_share_arb.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_share_pkg.sv
// Shared types and constants for the shared equality-compare arbiter.
package cmp_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic REQ_BR   = 1'b0;
   localparam logic REQ_TRAP = 1'b1;

endpackage

// File: rtl/cmp_share_arb_rr_arb2.sv
// Two-input round-robin grant; the pointer moves past the winner when upd is high.
module rr_arb2
   import cmp_share_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   logic ptr;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (ptr == REQ_TRAP) ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= REQ_BR;
      end else if (upd) begin
         ptr <= gnt[1] ? REQ_BR : REQ_TRAP;
      end
   end

endmodule

// File: rtl/cmp_share_arb.sv
// One 32-bit equality comparator shared by the branch unit and the trap unit.
module cmp_share_arb
   import cmp_share_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_ne,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_ne,
   output logic             req1_ready,
   input  logic             flush,
   output logic             rsp_valid,
   output logic             rsp_id,
   output logic             rsp_result,
   input  logic             rsp_ready,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [1:0]       gnt;
   logic             accept;
   logic [WIDTH-1:0] a_q, b_q;
   logic             ne_q, id_q;
   logic             rsp_id_q, rsp_result_q;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({req1_valid, req0_valid}),
      .upd   (accept),
      .gnt   (gnt)
   );

   assign req0_ready = (state_q == IDLE) && gnt[0] && !flush;
   assign req1_ready = (state_q == IDLE) && gnt[1] && !flush;
   assign accept     = req0_ready || req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = CMP;
         CMP:     state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         ne_q         <= 1'b0;
         id_q         <= REQ_BR;
         rsp_id_q     <= REQ_BR;
         rsp_result_q <= 1'b0;
      end else if (flush) begin
         a_q  <= '0;
         b_q  <= '0;
         ne_q <= 1'b0;
         id_q <= REQ_BR;
      end else begin
         if (accept) begin
            a_q  <= gnt[1] ? req1_a  : req0_a;
            b_q  <= gnt[1] ? req1_b  : req0_b;
            ne_q <= gnt[1] ? req1_ne : req0_ne;
            id_q <= gnt[1] ? REQ_TRAP : REQ_BR;
         end
         if (state_q == CMP) begin
            rsp_result_q <= (a_q == b_q) ^ ne_q;
            rsp_id_q     <= id_q;
         end
      end
   end

   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed bench for cmp_share_arb with hand-computed expectations.
module tb_cmp_share_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ne, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ne, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic        flush, rsp_valid, rsp_id, rsp_result, rsp_ready, busy;

   int unsigned errors = 0;
   int unsigned checks = 0;

   cmp_share_arb #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ne    (req0_ne),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ne    (req1_ne),
      .req1_ready (req1_ready),
      .flush      (flush),
      .rsp_valid  (rsp_valid),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_ready  (rsp_ready),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #13;
      rst_n = 1'b1;
      tick();
   endtask

   // Single request through to response; assumes IDLE on entry and leaves IDLE.
   task automatic run_single(input string tag, input logic port, input logic [31:0] a,
                             input logic [31:0] b, input logic ne, input logic exp_res);
      if (port) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_ne = ne;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_ne = ne;
      end
      #1;
      check({tag, ".ready0"}, {31'd0, req0_ready}, {31'd0, !port});
      check({tag, ".ready1"}, {31'd0, req1_ready}, {31'd0, port});
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      check({tag, ".busy_cmp"}, {31'd0, busy}, 32'd1);
      check({tag, ".valid_cmp"}, {31'd0, rsp_valid}, 32'd0);
      tick();
      check({tag, ".valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".id"}, {31'd0, rsp_id}, {31'd0, port});
      check({tag, ".result"}, {31'd0, rsp_result}, {31'd0, exp_res});
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check({tag, ".idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_ne = 0;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_ne = 0;
      flush = 0; rsp_ready = 0;
      rst_n = 1'b0;
      #2;
      check("rst.ready0", {31'd0, req0_ready}, 32'd0);
      check("rst.ready1", {31'd0, req1_ready}, 32'd0);
      check("rst.valid", {31'd0, rsp_valid}, 32'd0);
      check("rst.id", {31'd0, rsp_id}, 32'd0);
      check("rst.result", {31'd0, rsp_result}, 32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      do_reset();

      run_single("eq0", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
      run_single("bit1ne", 1'b1, 32'hFFFFEFFF, 32'hFFFFFFFF, 1'b1, 1'b1);
      run_single("bit1eq", 1'b1, 32'hFFFFEFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
      run_single("msb0", 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);

      // Contention: grants alternate starting with requester 0, one result per 3 cycles.
      do_reset();
      req0_valid = 1; req0_a = 32'h1234; req0_b = 32'h1234; req0_ne = 0;
      req1_valid = 1; req1_a = 32'd5;    req1_b = 32'd6;    req1_ne = 0;
      rsp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("rr.ready0", {31'd0, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
         check("rr.ready1", {31'd0, req1_ready}, (i % 2 == 0) ? 32'd0 : 32'd1);
         tick();
         check("rr.nordy0", {31'd0, req0_ready}, 32'd0);
         tick();
         check("rr.valid", {31'd0, rsp_valid}, 32'd1);
         check("rr.id", {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
         check("rr.result", {31'd0, rsp_result}, (i % 2 == 0) ? 32'd1 : 32'd0);
         tick();
         check("rr.idle", {31'd0, busy}, 32'd0);
      end
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;

      // Backpressure: result held while rsp_ready low; req0 waits.
      req0_valid = 1; req0_a = 32'hA5A5_0000; req0_b = 32'hA5A5_0001; req0_ne = 1;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp.valid", {31'd0, rsp_valid}, 32'd1);
         check("bp.id", {31'd0, rsp_id}, 32'd0);
         check("bp.result", {31'd0, rsp_result}, 32'd1);
         check("bp.ready0", {31'd0, req0_ready}, 32'd0);
         tick();
      end
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
      check("bp.idle", {31'd0, busy}, 32'd0);
      check("bp.reaccept", {31'd0, req0_ready}, 32'd1);
      tick();
      req0_valid = 0;
      check("bp.busy", {31'd0, busy}, 32'd1);
      tick();
      rsp_ready = 1;
      tick();
      rsp_ready = 0;

      // Flush in CMP: pointer already moved to requester 1 by the grant.
      do_reset();
      req0_valid = 1; req0_a = 32'd7; req0_b = 32'd7; req0_ne = 0;
      tick();
      req0_valid = 0;
      flush = 1;
      tick();
      flush = 0;
      check("fl_cmp.busy", {31'd0, busy}, 32'd0);
      check("fl_cmp.valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("fl_cmp.valid2", {31'd0, rsp_valid}, 32'd0);
      // Flush in IDLE blocks both readies and keeps the pointer.
      req0_valid = 1; req1_valid = 1;
      req1_a = 32'd3; req1_b = 32'd3; req1_ne = 1;
      flush = 1;
      #1;
      check("fl_idle.ready0", {31'd0, req0_ready}, 32'd0);
      check("fl_idle.ready1", {31'd0, req1_ready}, 32'd0);
      tick();
      flush = 0;
      #1;
      check("fl_idle.busy", {31'd0, busy}, 32'd0);
      check("fl_ptr.ready0", {31'd0, req0_ready}, 32'd0);
      check("fl_ptr.ready1", {31'd0, req1_ready}, 32'd1);
      tick();
      req0_valid = 0; req1_valid = 0;
      tick();
      check("fl_resp.valid", {31'd0, rsp_valid}, 32'd1);
      check("fl_resp.id", {31'd0, rsp_id}, 32'd1);
      check("fl_resp.result", {31'd0, rsp_result}, 32'd0);
      flush = 1; rsp_ready = 1;
      tick();
      flush = 0; rsp_ready = 0;
      check("fl_resp.drop", {31'd0, rsp_valid}, 32'd0);
      check("fl_resp.busy", {31'd0, busy}, 32'd0);

      // Async reset while a result is waiting in RESP.
      req1_valid = 1; req1_a = 32'd9; req1_b = 32'd9; req1_ne = 0;
      tick();
      req1_valid = 0;
      tick();
      check("ar.valid_pre", {31'd0, rsp_valid}, 32'd1);
      check("ar.id_pre", {31'd0, rsp_id}, 32'd1);
      #2;
      rst_n = 0;
      #1;
      check("ar.valid", {31'd0, rsp_valid}, 32'd0);
      check("ar.busy", {31'd0, busy}, 32'd0);
      check("ar.id", {31'd0, rsp_id}, 32'd0);
      check("ar.result", {31'd0, rsp_result}, 32'd0);
      #3;
      rst_n = 1;
      req0_valid = 1; req1_valid = 1;
      #1;
      check("ar.win0", {31'd0, req0_ready}, 32'd1);
      check("ar.lose1", {31'd0, req1_ready}, 32'd0);
      req0_valid = 0; req1_valid = 0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
